// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central sequencer for the 5-stage rv32i_core pipeline.
// Produces per-stage enables and flushes from load-use hazards, taken branches
// and memory wait states. It also owns debug run/halt/single-step control and
// keeps saturating stall and flush cycle counters.
module pipeline_ctrl #(
  parameter int CNT_W         = 32,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             halt,
  input  logic             step,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pc_sel_branch,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_STEP   = 2'b10
  } state_t;

  localparam state_t          RESET_STATE = (HALT_ON_RESET != 1'b0) ? ST_HALTED : ST_RUN;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             step_prev_q, step_prev_d;
  logic             halted_q, halted_d;
  logic             step_done_q, step_done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             active_s;
  logic             load_use_s;
  logic             step_rise_s;

  // Hazard detection: a load into a nonzero register that ID is about to read.
  always_comb begin
    active_s    = (state_q == ST_RUN) || (state_q == ST_STEP);
    step_rise_s = step && !step_prev_q;
    load_use_s  = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Stage enables and flushes; memory wait beats branch, branch beats load-use.
  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    pc_sel_branch = 1'b0;
    if (!active_s) begin
      pc_en = 1'b0;
    end else if (mem_busy) begin
      pc_en = 1'b0;
    end else if (ex_branch_taken) begin
      // The ID instruction is on the wrong path, so any load-use stall is moot.
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
      ex_mem_en     = 1'b1;
      mem_wb_en     = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      pc_sel_branch = 1'b1;
    end else if (load_use_s) begin
      // Hold PC and IF/ID; ID/EX captures a bubble while the load moves on.
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
    end
  end

  // Debug FSM next state; a halt or step completion waits for memory to settle.
  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    step_prev_d = step;
    case (state_q)
      ST_RUN: begin
        if (halt && !mem_busy) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (!halt) begin
          state_d = ST_RUN;
        end else if (step_rise_s) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_STEP: begin
        if (!mem_busy) begin
          state_d     = ST_HALTED;
          step_done_d = 1'b1;
        end else begin
          state_d = ST_STEP;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  // Saturating performance counters; frozen while halted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (active_s && !pc_en && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (if_id_flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State, status and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      step_prev_q <= 1'b0;
      halted_q    <= (RESET_STATE == ST_HALTED);
      step_done_q <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      step_prev_q <= step_prev_d;
      halted_q    <= halted_d;
      step_done_q <= step_done_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted    = halted_q;
  assign step_done = step_done_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a
// cycle-level behavioural model built from the sequencing rules.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, halt, step;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_busy;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, pc_sel_branch, halted, step_done;
  logic [3:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  // Behavioural model: "halted" and "stepping" flags, step history, counters.
  bit m_halted, m_step, m_sd, m_prev;
  int m_stall, m_flush;

  pipeline_ctrl #(.CNT_W(4), .HALT_ON_RESET(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .halt(halt), .step(step),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .pc_sel_branch(pc_sel_branch), .halted(halted),
    .step_done(step_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs: {pc,ifid,idex,exmem,memwb,fif,fid,sel,halted,step_done,stall[3:0],flush[3:0]}
  function automatic logic [17:0] expect_vec();
    bit lu, pc, ifid, idex, exm, mwb, fif, fid, sel;
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    {pc, ifid, idex, exm, mwb, fif, fid, sel} = 8'h00;
    if (!m_halted && !mem_busy) begin
      if (ex_branch_taken) {pc, ifid, idex, exm, mwb, fif, fid, sel} = 8'hFF;
      else if (lu)         {pc, ifid, idex, exm, mwb, fif, fid, sel} = 8'b0011_1010;
      else                 {pc, ifid, idex, exm, mwb, fif, fid, sel} = 8'b1111_1000;
    end
    return {pc, ifid, idex, exm, mwb, fif, fid, sel, m_halted, m_sd, 4'(m_stall), 4'(m_flush)};
  endfunction

  function automatic logic [17:0] observed_vec();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
            pc_sel_branch, halted, step_done, stall_cnt, flush_cnt};
  endfunction

  task automatic model_reset();
    m_halted = 1'b0; m_step = 1'b0; m_sd = 1'b0; m_prev = 1'b0;
    m_stall = 0; m_flush = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: compare everything before the edge, then advance the model.
  task automatic cycle(input string tag);
    logic [17:0] e;
    #1;
    e = expect_vec();
    chk(tag, 32'(observed_vec()), 32'(e));
    @(posedge clk);
    if (!m_halted && !e[17] && m_stall < 15) m_stall++;
    if (e[12] && m_flush < 15) m_flush++;
    m_sd = m_step && !mem_busy;
    if (m_step) begin
      if (!mem_busy) begin m_step = 1'b0; m_halted = 1'b1; end
    end else if (m_halted) begin
      if (!halt) m_halted = 1'b0;
      else if (step && !m_prev) begin m_halted = 1'b0; m_step = 1'b1; end
    end else begin
      if (halt && !mem_busy) m_halted = 1'b1;
    end
    m_prev = step;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    halt = 1'b0; step = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_step_done", 32'(step_done), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle("idle");

    // Load-use on rs1 = x5: one stall cycle with a bubble.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_if_id_en", 32'(if_id_en), 32'd0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    cycle("load_use");
    idle_inputs();
    #1 chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    cycle("after_lu");

    // Load-use on rs2 only.
    ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1; id_rs1 = 5'd9;
    cycle("load_use_rs2");
    id_use_rs2 = 1'b0;
    cycle("rs_match_not_used");

    // Load into x0 never stalls.
    idle_inputs();
    ex_mem_read = 1'b1; id_use_rs1 = 1'b1;
    #1 chk("x0_pc_en", 32'(pc_en), 32'd1);
    cycle("x0_load");

    // Branch together with load-use: branch wins.
    ex_rd = 5'd7; id_rs1 = 5'd7; ex_branch_taken = 1'b1;
    #1;
    chk("br_lu_pc_en", 32'(pc_en), 32'd1);
    chk("br_lu_sel", 32'(pc_sel_branch), 32'd1);
    cycle("branch_and_lu");
    idle_inputs();
    #1 chk("br_flush_cnt", 32'(flush_cnt), 32'd1);

    // Halt request while memory busy for 3 cycles.
    halt = 1'b1; mem_busy = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) cycle("halt_busy");
    #1 chk("halt_wait_busy", 32'(halted), 32'd0);
    mem_busy = 1'b0; ex_branch_taken = 1'b0;
    cycle("halt_release");
    #1 chk("halted_rise", 32'(halted), 32'd1);
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    cycle("halted_ignores");

    // Two single steps.
    for (int k = 0; k < 2; k++) begin
      step = 1'b1; cycle("step_edge");
      step = 1'b0; cycle("step_adv");
      #1 chk("step_done_pulse", 32'(step_done), 32'd1);
      cycle("step_back");
    end
    #1 chk("step_done_low", 32'(step_done), 32'd0);
    // Holding step high yields only one step.
    step = 1'b1;
    for (int i = 0; i < 5; i++) cycle("step_hold");
    #1 chk("step_hold_halted", 32'(halted), 32'd1);
    step = 1'b0;
    cycle("step_drop");

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      halt            = ($urandom_range(0, 9) < 3);
      step            = $urandom_range(0, 1) == 1;
      mem_busy        = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      ex_mem_read     = $urandom_range(0, 1) == 1;
      ex_rd           = 5'($urandom_range(0, 3));
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_use_rs1      = $urandom_range(0, 1) == 1;
      id_use_rs2      = $urandom_range(0, 1) == 1;
      cycle("random");
    end

    // Back to RUN, then saturate the flush counter.
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle("to_run");
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 18; i++) cycle("flush_sat");
    #1 chk("flush_saturated", 32'(flush_cnt), 32'd15);
    halt = 1'b1; ex_branch_taken = 1'b0;
    cycle("halt_again");
    step = 1'b1; mem_busy = 1'b1; ex_branch_taken = 1'b1;
    cycle("enter_step");
    cycle("step_busy");
    #1 chk("flush_still_15", 32'(flush_cnt), 32'd15);

    // Asynchronous reset in the middle of STEP.
    idle_inputs();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_halted", 32'(halted), 32'd0);
    chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
    chk("mid_rst_flush", 32'(flush_cnt), 32'd0);
    chk("mid_rst_pc_en", 32'(pc_en), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    halt = 1'b1;
    cycle("post_rst_halt");
    #1 chk("post_rst_halted", 32'(halted), 32'd1);
    idle_inputs();
    cycle("post_rst_run");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
